axis_width_downsizer: RTL and testbench

AXIS_WIDTH_DOWNSIZER -- requirements
Module: axis_width_downsizer

---
 rtl/axis_pkg.sv | 19 +
 rtl/axis_width_downsizer.sv | 74 +++++++
 tb/tb_axis_width_downsizer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream width downsizer.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned width_ratio(input int unsigned data_width,
                                              input int unsigned out_width);
    return data_width / out_width;
  endfunction

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_width_downsizer.sv
// Splits each DATA_WIDTH input word into little-endian OUT_WIDTH beats,
// framing every PKT_WORDS input words as one output packet.
module axis_width_downsizer
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned PKT_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tready,
  output logic                  m_tvalid,
  output logic [OUT_WIDTH-1:0]  m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam int unsigned RATIO  = width_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int unsigned BEAT_W = cnt_width(RATIO);
  localparam int unsigned WORD_W = cnt_width(PKT_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(PKT_WORDS - 1);

  state_t                state, state_next;
  logic [BEAT_W-1:0]     beat;
  logic [WORD_W-1:0]     word;
  logic [DATA_WIDTH-1:0] hold;
  logic                  last_beat, in_xfer, out_xfer;

  assign last_beat = (beat == BEAT_LAST);

  always_comb begin
    m_tvalid   = (state == SEND);
    // A new word may enter only as the final beat of the held word leaves.
    s_tready   = !rst && ((state == IDLE) || (last_beat && m_tready));
    in_xfer    = s_tvalid && s_tready;
    out_xfer   = m_tvalid && m_tready;
    m_tlast    = m_tvalid && last_beat && (word == WORD_LAST);
    m_tdata    = hold[OUT_WIDTH-1:0];
    state_next = state;
    case (state)
      IDLE:    if (in_xfer) state_next = SEND;
      SEND:    if (out_xfer && last_beat && !in_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      word  <= '0;
      hold  <= '0;
    end else begin
      state <= state_next;
      // Shifting the held word keeps the current beat in the low slice.
      if (in_xfer) begin
        hold <= s_tdata;
      end else if (out_xfer) begin
        hold <= hold >> OUT_WIDTH;
      end
      if (out_xfer) begin
        beat <= last_beat ? '0 : beat + BEAT_W'(1);
        if (last_beat) begin
          word <= (word == WORD_LAST) ? '0 : word + WORD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed and random checks of the width downsizer against a beat scoreboard.
module tb_axis_width_downsizer;

  localparam int unsigned DW    = 32;
  localparam int unsigned OW    = 8;
  localparam int unsigned PKT   = 16;
  localparam int unsigned RATIO = DW / OW;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid, s_tready, m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] s_tdata;
  logic [OW-1:0] m_tdata;
  logic          s1_tvalid, s1_tready, m1_tvalid, m1_tlast, m1_tready;
  logic [DW-1:0] s1_tdata;
  logic [OW-1:0] m1_tdata;

  beat_t       sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned beats_seen  = 0;
  int unsigned lasts_seen  = 0;
  int unsigned wmod        = 0;

  always #5 clk = ~clk;

  axis_width_downsizer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .PKT_WORDS(PKT)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  axis_width_downsizer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .PKT_WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_tvalid(s1_tvalid), .s_tdata(s1_tdata), .s_tready(s1_tready),
    .m_tvalid(m1_tvalid), .m_tdata(m1_tdata), .m_tlast(m1_tlast), .m_tready(m1_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    beat_t b;
    for (int unsigned k = 0; k < RATIO; k++) begin
      b.data = d[k*OW +: OW];
      b.last = (k == RATIO - 1) && (wmod == PKT - 1);
      sb.push_back(b);
    end
    wmod = (wmod == PKT - 1) ? 0 : wmod + 1;
  endtask

  // Scoreboard: every presented beat must match the queue head, stalled or not.
  always @(negedge clk) begin
    if (!rst && m_tvalid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow: observed beat %h expected no beat", m_tdata);
      end else begin
        chk("m_tdata", 32'(m_tdata), 32'(sb[0].data));
        chk("m_tlast", 32'(m_tlast), 32'(sb[0].last));
        if (m_tready) begin
          sb.pop_front();
          beats_seen++;
          if (m_tlast) lasts_seen++;
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send(input logic [DW-1:0] d, output int unsigned waits);
    s_tvalid = 1'b1;
    s_tdata  = d;
    waits    = 0;
    @(negedge clk);
    while (!s_tready && waits < 1000) begin
      waits++;
      @(negedge clk);
    end
    chk("send_accept", 32'(s_tready), 32'd1);
    if (s_tready) push_word(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    s_tvalid = 1'b0;
    @(negedge clk);
    while ((m_tvalid || sb.size() != 0) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    wmod = 0;
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast",  32'(m_tlast),  32'd0);
    chk("rst_m_tdata",  32'(m_tdata),  32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_s1_tready", 32'(s1_tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned w, acc, b1, n, cyc, base, lbase;
    logic        taken;
    logic [DW-1:0] d1;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s1_tvalid = 1'b0; s1_tdata = '0; m1_tready = 1'b1;

    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("s_tready_after_rst", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;

    // Single word: one-cycle latency, four consecutive beats.
    send(32'hDDCCBBAA, w);
    s_tvalid = 1'b0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      @(negedge clk);
      chk("single_valid", 32'(m_tvalid), 32'd1);
    end
    @(negedge clk);
    chk("single_idle", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back packet: s_tready only on the final beat of each word.
    do_reset();
    lbase = lasts_seen;
    for (int unsigned i = 0; i < PKT; i++) begin
      send(DW'(i), w);
      if (i > 0) chk("b2b_ready_gap", w, 32'd3);
    end
    drain();
    chk("b2b_tlast_count", lasts_seen - lbase, 32'd1);

    // Backpressure on the third beat.
    send(32'h44332211, w);
    s_tvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_data",  32'(m_tdata),  32'h33);
      chk("stall_valid", 32'(m_tvalid), 32'd1);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    drain();

    // Reset after seven words and two beats of the eighth.
    do_reset();
    base = beats_seen;
    for (int unsigned i = 0; i < 8; i++) send(32'hA5000000 | DW'(i), w);
    s_tvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (beats_seen < base + 7 * RATIO + 2 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("midpkt_reach", beats_seen - base, 7 * RATIO + 2);
    @(posedge clk);
    #1;
    do_reset();
    lbase = lasts_seen;
    base  = beats_seen;
    for (int unsigned i = 0; i < PKT; i++) send(32'h5A000000 | DW'(i), w);
    drain();
    chk("post_rst_beats", beats_seen - base, PKT * RATIO);
    chk("post_rst_tlast", lasts_seen - lbase, 32'd1);

    // Single-word packets on the second instance.
    d1 = 32'h11223344;
    s1_tvalid = 1'b1;
    s1_tdata  = d1;
    acc = 0;
    b1  = 0;
    for (int unsigned c = 0; c < 14; c++) begin
      @(negedge clk);
      if (m1_tvalid) begin
        chk("p1_tdata", 32'(m1_tdata), 32'(d1[(b1 % RATIO)*OW +: OW]));
        b1++;
        chk("p1_tlast", 32'(m1_tlast), 32'(b1 % RATIO == 0));
      end else begin
        chk("p1_tlast_idle", 32'(m1_tlast), 32'd0);
      end
      if (s1_tvalid && s1_tready) acc++;
      @(posedge clk);
      #1;
      if (acc == 2) s1_tvalid = 1'b0;
    end
    chk("p1_beats", b1, 2 * RATIO);

    // Random valid/ready over 10k words.
    lbase = lasts_seen;
    base  = beats_seen;
    taken = 1'b0;
    n   = 0;
    cyc = 0;
    while ((n < 10000 || sb.size() != 0 || s_tvalid) && cyc < 90000) begin
      if (taken) s_tvalid = 1'b0;
      m_tready = ($urandom_range(0, 7) != 0);
      if (!s_tvalid && n < 10000 && $urandom_range(0, 3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
      end
      @(negedge clk);
      taken = s_tvalid && s_tready;
      if (taken) begin
        push_word(s_tdata);
        n++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand_words", n, 32'd10000);
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_beats", beats_seen - base, 10000 * RATIO);
    chk("rand_lasts", lasts_seen - lbase, 10000 / PKT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
